exec_stage: RTL and testbench

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/exec_pkg.sv | 22 ++
 rtl/seq_mult.sv | 55 +++++
 rtl/exec_stage.sv | 137 +++++++++++++
 tb/tb_exec_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU opcodes and control FSM states.
// No logic, no latency.
// No flow control; types only.
package exec_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5,
        OP_NOR = 3'd6,
        OP_MUL = 3'd7
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier, low XLEN bits of the product.
// Latency: start edge loads operands, done is asserted during the XLEN-th cycle after it.
// No backpressure: product is valid combinationally while done is high, for one cycle only.
module seq_mult #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] acc_step;
    logic [CW-1:0]   cnt_q;
    logic            run_q;

    // The final step is folded into the done cycle so the caller captures it directly.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done     = run_q && (cnt_q == LAST);
    assign product  = acc_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: ALU, branch target adder, iterative MUL behind a registered output slot.
// Latency: 1 cycle for ALU ops, XLEN+1 cycles for MUL.
// Backpressure: output slot holds while out_ready is low; in_ready drops while full or multiplying.
module exec_stage
    import exec_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int IMM_W   = 16,
    parameter int MULT_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  pc,
    input  logic [IMM_W-1:0] imm,
    input  logic [XLEN-1:0]  rs_val,
    input  logic [XLEN-1:0]  rt_val,
    input  logic             alu_src,
    input  logic [2:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_result,
    output logic [XLEN-1:0]  branch_target,
    output logic             zero,
    output logic             busy
);

    localparam bit MUL_ON = (MULT_EN != 0);
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    state_e          state_q;
    state_e          state_d;
    alu_op_e         op;
    logic [XLEN-1:0] imm_sx;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_comb;
    logic [XLEN-1:0] tgt_comb;
    logic [XLEN-1:0] prod;
    logic            slt;
    logic            is_mul;
    logic            accept;
    logic            mul_start;
    logic            mul_done;

    assign op       = alu_op_e'(alu_op);
    assign imm_sx   = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    assign op_b     = alu_src ? imm_sx : rt_val;
    assign tgt_comb = pc + FOUR + {imm_sx[XLEN-3:0], 2'b00};
    assign slt      = $signed(rs_val) < $signed(op_b);
    assign is_mul   = MUL_ON && (op == OP_MUL);

    assign in_ready = (state_q == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == ST_MUL);

    always_comb begin
        alu_comb = rs_val + op_b;
        case (op)
            OP_SUB:  alu_comb = rs_val - op_b;
            OP_AND:  alu_comb = rs_val & op_b;
            OP_OR:   alu_comb = rs_val | op_b;
            OP_XOR:  alu_comb = rs_val ^ op_b;
            OP_SLT:  alu_comb = {{(XLEN-1){1'b0}}, slt};
            OP_NOR:  alu_comb = ~(rs_val | op_b);
            // ADD, and MUL when the multiplier is compiled out
            default: alu_comb = rs_val + op_b;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_mul) begin
                    state_d   = ST_MUL;
                    mul_start = 1'b1;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    seq_mult #(
        .XLEN(XLEN)
    ) u_mult (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .a      (rs_val),
        .b      (op_b),
        .done   (mul_done),
        .product(prod)
    );

    // A MUL accept only ever coincides with an empty or draining slot, so its
    // target can be written early and simply waits for the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            alu_result    <= '0;
            branch_target <= '0;
            zero          <= 1'b0;
        end else if (mul_done) begin
            out_valid  <= 1'b1;
            alu_result <= prod;
            zero       <= (prod == '0);
        end else if (accept && !is_mul) begin
            out_valid     <= 1'b1;
            alu_result    <= alu_comb;
            branch_target <= tgt_comb;
            zero          <= (alu_comb == '0);
        end else begin
            if (accept) begin
                branch_target <= tgt_comb;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: directed literal cases plus randomized traffic against a
// cycle-level behavioural model that checks outputs every cycle.
module tb_exec_stage;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] pc = '0;
    logic [15:0] imm = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        alu_src = 1'b0;
    logic [2:0]  alu_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_result;
    logic [31:0] branch_target;
    logic        zero;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    exec_stage #(.XLEN(32), .IMM_W(16), .MULT_EN(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pc           (pc),
        .imm          (imm),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_result   (alu_result),
        .branch_target(branch_target),
        .zero         (zero),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return ~(a | b);
            default: return a * b;
        endcase
    endfunction

    // Behavioural model: one output slot plus a pending multiply countdown.
    logic        m_valid = 1'b0;
    logic        m_pend = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res = '0;
    logic [31:0] m_tgt = '0;
    logic        m_zero = 1'b0;
    logic [31:0] m_mres = '0;

    always @(negedge clk) begin : model
        logic        exp_rdy;
        logic [31:0] b, r;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_alu_result", alu_result, 0);
            chk("rst_branch_target", branch_target, 0);
            chk("rst_zero", zero, 0);
            m_valid = 1'b0;
            m_pend  = 1'b0;
            m_left  = 0;
        end else begin
            exp_rdy = !m_pend && (!m_valid || out_ready);
            chk("in_ready", in_ready, exp_rdy);
            chk("out_valid", out_valid, m_valid);
            chk("busy", busy, m_pend);
            if (m_valid) begin
                chk("alu_result", alu_result, m_res);
                chk("branch_target", branch_target, m_tgt);
                chk("zero", zero, m_zero);
            end
            if (m_pend) begin
                m_left--;
                if (m_left == 0) begin
                    m_pend  = 1'b0;
                    m_valid = 1'b1;
                    m_res   = m_mres;
                    m_zero  = (m_mres == 0);
                end
            end else begin
                if (m_valid && out_ready) m_valid = 1'b0;
                if (in_valid && exp_rdy) begin
                    b     = alu_src ? sext(imm) : rt_val;
                    r     = ref_alu(alu_op, rs_val, b);
                    m_tgt = pc + 32'd4 + (sext(imm) * 32'd4);
                    if (alu_op == 3'd7) begin
                        m_pend = 1'b1;
                        m_left = XLEN;
                        m_mres = r;
                    end else begin
                        m_valid = 1'b1;
                        m_res   = r;
                        m_zero  = (r == 0);
                    end
                end
            end
        end
    end

    // Offer one op and return #1 after the edge that accepted it.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] bb,
                         input logic [15:0] im, input logic src, input logic [31:0] p);
        logic ok;
        @(posedge clk);
        #1;
        alu_op = o; rs_val = a; rt_val = bb; imm = im; alu_src = src; pc = p;
        in_valid = 1'b1;
        out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        chk("issue_accept_timeout", ok, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin : stim
        int          idx, bcnt, vcnt, acc_n, got_n;
        logic [31:0] got [4];

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("lit_ready_after_reset", in_ready, 1);
        chk("lit_valid_after_reset", out_valid, 0);

        issue(3'd0, 32'd5, 32'd7, 16'h0000, 1'b0, 32'h0);
        @(negedge clk);
        chk("lit_add_valid", out_valid, 1);
        chk("lit_add_result", alu_result, 12);
        chk("lit_add_zero", zero, 0);

        issue(3'd1, 32'h1234, 32'h1234, 16'h0000, 1'b0, 32'h0);
        @(negedge clk);
        chk("lit_sub_result", alu_result, 0);
        chk("lit_sub_zero", zero, 1);

        issue(3'd5, 32'hFFFF_FFFF, 32'h0, 16'h0001, 1'b1, 32'h0);
        @(negedge clk);
        chk("lit_slt_result", alu_result, 1);

        issue(3'd0, 32'h0, 32'h0, 16'hFFFE, 1'b0, 32'h100);
        @(negedge clk);
        chk("lit_target_neg", branch_target, 32'hFC);

        issue(3'd0, 32'h0, 32'h0, 16'h0003, 1'b0, 32'h100);
        @(negedge clk);
        chk("lit_target_pos", branch_target, 32'h110);

        issue(3'd7, 32'd6, 32'd7, 16'h0002, 1'b0, 32'h200);
        idx = 0; bcnt = 0;
        for (int i = 1; i <= 40 && idx == 0; i++) begin
            @(negedge clk);
            if (out_valid) idx = i;
            else if (busy && !in_ready) bcnt++;
        end
        chk("lit_mul_busy_cycles", bcnt, 32);
        chk("lit_mul_valid_cycle", idx, 33);
        chk("lit_mul_result", alu_result, 42);
        chk("lit_mul_target", branch_target, 32'h20C);

        // Back-to-back ADDs into a stalled output slot, then drain.
        @(posedge clk);
        #1;
        acc_n = 0; got_n = 0;
        for (int cyc = 0; cyc < 60 && got_n < 4; cyc++) begin
            out_ready = (cyc >= 6);
            in_valid  = (acc_n < 4);
            alu_op = 3'd0; alu_src = 1'b0;
            rs_val = 32'd101 + 32'(acc_n); rt_val = 32'd0;
            @(negedge clk);
            if (cyc == 4) begin
                chk("lit_b2b_stall_ready", in_ready, 0);
                chk("lit_b2b_hold_valid", out_valid, 1);
                chk("lit_b2b_hold_result", alu_result, 101);
            end
            if (out_valid && out_ready) begin
                got[got_n] = alu_result;
                got_n++;
            end
            if (in_valid && in_ready) acc_n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("lit_b2b_count", got_n, 4);
        for (int i = 0; i < got_n; i++) chk("lit_b2b_order", got[i], 32'd101 + 32'(i));

        // Reset in the middle of a multiply.
        issue(3'd7, 32'd3, 32'd5, 16'h0000, 1'b0, 32'h0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_midmul_rst_valid", out_valid, 0);
        chk("lit_midmul_rst_busy", busy, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("lit_ready_after_abort", in_ready, 1);
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        chk("lit_no_result_after_abort", vcnt, 0);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            alu_op    = 3'($urandom_range(0, 7));
            alu_src   = 1'($urandom_range(0, 1));
            rs_val    = $urandom;
            rt_val    = ($urandom_range(0, 5) == 0) ? rs_val : $urandom;
            if ($urandom_range(0, 3) == 0) begin
                rs_val = 32'($urandom_range(0, 20));
                rt_val = 32'($urandom_range(0, 20));
            end
            imm = 16'($urandom);
            pc  = $urandom;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
